// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory: sub-word slicing, RMW byte/half stores, fault checks.
// Optional define LSU_FWD_EN adds a one-entry last-write buffer that lets matching loads skip the memory read.
module load_store_unit #(
  parameter int MEM_WORDS = 200,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ls_valid,
  input  logic              ls_load,
  input  logic              ls_store,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              ls_fault,
  output logic [1:0]        ls_cause,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       ALUOut,
  output logic [31:0]       reg2data,
  input  logic [31:0]       memout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  logic [2:0]  state;
  logic        load_p1;
  logic        signed_p1;
  logic [1:0]  size_p1;
  logic [1:0]  lane_p1;
  logic [31:0] wdata_p1;

  logic        accept;
  logic        illegal_c;
  logic        misal_c;
  logic        oor_c;
  logic        hit_c;
  logic [1:0]  cause_c;
  logic [31:0] idx_c;
  logic [31:0] fwd_word;

  function automatic logic [31:0] lane_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00:   m[{lane, 3'b000} +: 8] = d[7:0];
      2'b01:   if (lane[1]) m[31:16] = d[15:0]; else m[15:0] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  assign ls_ready = (state == S_IDLE);
  assign ls_done  = (state == S_DONE) || (state == S_FLT);
  assign ls_fault = (state == S_FLT);
  assign MemRead  = (state == S_RD);
  assign MemWrite = (state == S_WR);

  assign accept    = ls_valid & ls_ready;
  assign idx_c     = 32'(ls_addr[ADDR_W-1:2]);
  assign illegal_c = (ls_size == 2'b11) || (ls_load == ls_store);
  assign misal_c   = ((ls_size == 2'b01) && ls_addr[0]) || ((ls_size == 2'b10) && (ls_addr[1:0] != 2'b00));
  assign oor_c     = (idx_c >= 32'(MEM_WORDS));

  always_comb begin
    cause_c = 2'b00;
    if (illegal_c)    cause_c = 2'b11;
    else if (misal_c) cause_c = 2'b01;
    else if (oor_c)   cause_c = 2'b10;
  end

`ifdef LSU_FWD_EN
  logic        fwd_vld;
  logic [31:0] fwd_idx;
  logic [31:0] fwd_data;

  assign hit_c    = ls_load & fwd_vld & (fwd_idx == idx_c);
  assign fwd_word = fwd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fwd_vld <= 1'b0;
    else if (state == S_WR)  fwd_vld <= 1'b1;
  end

  // memory is only written by this unit, so the last write is always current
  always_ff @(posedge clk) begin
    if (state == S_WR) begin
      fwd_idx  <= ALUOut;
      fwd_data <= reg2data;
    end
  end
`else
  assign hit_c    = 1'b0;
  assign fwd_word = 32'h0;
`endif

  // p1: request captured at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      load_p1   <= ls_load;
      signed_p1 <= ls_signed;
      size_p1   <= ls_size;
      lane_p1   <= ls_addr[1:0];
      wdata_p1  <= ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ls_cause <= 2'b00;
      ls_rdata <= 32'h0;
      ALUOut   <= 32'h0;
      reg2data <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cause_c != 2'b00) begin
              ls_cause <= cause_c;
              state    <= S_FLT;
            end else begin
              ls_cause <= 2'b00;
              ALUOut   <= idx_c;
              if (hit_c) begin
                ls_rdata <= lane_load(fwd_word, ls_size, ls_addr[1:0], ls_signed);
                state    <= S_DONE;
              end else if (ls_store && (ls_size == 2'b10)) begin
                reg2data <= ls_wdata;
                state    <= S_WR;
              end else begin
                state    <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (load_p1) begin
            ls_rdata <= lane_load(memout, size_p1, lane_p1, signed_p1);
            state    <= S_DONE;
          end else begin
            reg2data <= store_merge(memout, wdata_p1, size_p1, lane_p1);
            state    <= S_WR;
          end
        end
        S_WR:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and randomized requests vs a word-array model.
module tb_load_store_unit;

`ifdef LSU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid, ls_load, ls_store, ls_signed;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_ready, ls_done, ls_fault;
  logic [31:0] ls_rdata;
  logic [1:0]  ls_cause;
  logic        MemRead, MemWrite;
  logic [31:0] ALUOut, reg2data, memout;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(200), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_load(ls_load), .ls_store(ls_store),
    .ls_size(ls_size), .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .ls_cause(ls_cause), .MemRead(MemRead), .MemWrite(MemWrite), .ALUOut(ALUOut),
    .reg2data(reg2data), .memout(memout)
  );

  // memory behind the port
  logic [31:0] mem [0:199];
  assign memout = (ALUOut < 32'd200) ? mem[ALUOut[7:0]] : 32'h0;
  always @(posedge clk) if (MemWrite && (ALUOut < 32'd200)) mem[ALUOut[7:0]] <= reg2data;

  typedef struct {
    logic ld; logic st; logic [1:0] sz; logic sg;
    logic [31:0] addr; logic [31:0] wd;
    logic [31:0] rdata; logic flt; logic [1:0] cause;
    int lat; int rdc; int wrc; logic [31:0] r2d;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  logic [31:0] ref_mem [0:199];
  bit          lw_vld;
  int          lw_idx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                     input logic flt, input logic [1:0] cause, input int lat, input int rdc,
                     input int wrc, input logic [31:0] r2d);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.flt = flt; v.cause = cause; v.lat = lat; v.rdc = rdc; v.wrc = wrc; v.r2d = r2d;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] lo, input logic sg);
    logic [31:0] mask, top, v;
    int sh;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin mask = 32'hFF; sh = 8 * int'(lo); end
    else begin mask = 32'hFFFF; sh = 16 * int'(lo[1]); end
    top = (mask >> 1) + 32'd1;
    v = (w >> sh) & mask;
    if (sg && ((v & top) != 32'd0)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return d;
    if (sz == 2'd0) begin mask = 32'hFF; sh = 8 * int'(lo); end
    else begin mask = 32'hFFFF; sh = 16 * int'(lo[1]); end
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  function automatic logic [1:0] m_cause(input logic ld, input logic st, input logic [1:0] sz,
                                         input logic [31:0] a);
    if (sz == 2'd3 || ld == st) return 2'd3;
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) return 2'd1;
    if ((a >> 2) >= 32'd200) return 2'd2;
    return 2'd0;
  endfunction

  // reference: expected outcome of one request, updating the model memory
  task automatic model(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output vec_t e);
    int idx;
    logic [31:0] nw;
    e.ld = ld; e.st = st; e.sz = sz; e.sg = sg; e.addr = a; e.wd = wd;
    e.rdata = 32'h0; e.flt = 1'b0; e.r2d = 32'h0; e.lat = 0; e.rdc = 0; e.wrc = 0;
    e.cause = m_cause(ld, st, sz, a);
    if (e.cause != 2'd0) begin
      e.flt = 1'b1; e.lat = 1;
    end else begin
      idx = int'(a >> 2);
      if (ld) begin
        e.rdata = m_load(ref_mem[idx], sz, a[1:0], sg);
        if (FWD && lw_vld && lw_idx == idx) e.lat = 1;
        else begin e.lat = 2; e.rdc = 1; end
      end else begin
        nw = m_merge(ref_mem[idx], wd, sz, a[1:0]);
        ref_mem[idx] = nw;
        e.r2d = nw;
        lw_vld = 1'b1;
        lw_idx = idx;
        if (sz == 2'd2) begin e.lat = 2; e.wrc = 1; end
        else begin e.lat = 3; e.rdc = 1; e.wrc = 2; end
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat = 0, rdc = 0, wrc = 0, nrd = 0, nwr = 0;
    logic [31:0] alu_rd = 32'h0, r2d = 32'h0, rd = 32'h0;
    logic flt = 1'b0, both = 1'b0, busy_rdy = 1'b0;
    logic [1:0] cs = 2'b00;
    for (int i = 0; i < 10 && !ls_ready; i++) @(negedge clk);
    ls_valid = 1'b1; ls_load = v.ld; ls_store = v.st; ls_size = v.sz; ls_signed = v.sg;
    ls_addr = v.addr; ls_wdata = v.wd;
    @(posedge clk);
    #1;
    ls_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (MemRead && MemWrite) both = 1'b1;
      if (MemRead) begin nrd++; if (rdc == 0) begin rdc = c; alu_rd = ALUOut; end end
      if (MemWrite) begin nwr++; if (wrc == 0) begin wrc = c; r2d = reg2data; end end
      if (ls_ready) busy_rdy = 1'b1;
      if (ls_done) begin lat = c; rd = ls_rdata; flt = ls_fault; cs = ls_cause; break; end
    end
    if (nrd > 1) rdc = 99;
    if (nwr > 1) wrc = 99;
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_fault"}, 32'(flt), 32'(v.flt));
    check({tag, "_cause"}, 32'(cs), 32'(v.cause));
    check({tag, "_read_cycle"}, 32'(rdc), 32'(v.rdc));
    check({tag, "_write_cycle"}, 32'(wrc), 32'(v.wrc));
    check({tag, "_both_strobes"}, 32'(both), 32'd0);
    check({tag, "_ready_busy"}, 32'(busy_rdy), 32'd0);
    if (v.ld && !v.flt) check({tag, "_rdata"}, rd, v.rdata);
    if (v.rdc != 0) check({tag, "_aluout"}, alu_rd, v.addr >> 2);
    if (v.wrc != 0) check({tag, "_reg2data"}, r2d, v.r2d);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(ls_ready), 32'd1);
    if (v.ld && !v.flt) check({tag, "_rdata_held"}, ls_rdata, v.rdata);
  endtask

  initial begin
    vec_t m;
    logic seen;
    logic [1:0] sz, lo;
    logic ld, st;
    int idx, r;

    ls_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0;
    for (int i = 0; i < 200; i++) begin mem[i] <= 32'h0; ref_mem[i] = 32'h0; end
    mem[8] <= 32'hF0F0F0F0; mem[10] <= 32'h00000005;
    ref_mem[8] = 32'hF0F0F0F0; ref_mem[10] = 32'h00000005;
    lw_vld = 1'b0; lw_idx = 0;

    // directed vectors: ld st sz sg addr wdata | rdata fault cause lat rd_cyc wr_cyc reg2data
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h28,  32'h0,        32'h00000005, 1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 2'd0, 1'b1, 32'h21,  32'h0,        32'hFFFFFFF0, 1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'h0000F0F0, 1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b0, 1'b1, 2'd0, 1'b0, 32'h23,  32'hFFFFFFAB, 32'h0,        1'b0, 2'd0, 3, 1, 2, 32'hABF0F0F0);
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'hABF0F0F0, 1'b0, 2'd0, FWD ? 1 : 2, FWD ? 0 : 1, 0, 32'h0);
    add(1'b1, 1'b0, 2'd1, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1, 2'd1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h320, 32'h0,        32'h0,        1'b1, 2'd2, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 2'd3, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 2'd3, 1, 0, 0, 32'h0);
    add(1'b1, 1'b1, 2'd2, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 2'd3, 1, 0, 0, 32'h0);
    add(1'b0, 1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 2'd3, 1, 0, 0, 32'h0);
    add(1'b0, 1'b1, 2'd2, 1'b0, 32'h22,  32'h1,        32'h0,        1'b1, 2'd1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 2'd3, 1'b0, 32'h321, 32'h0,        32'h0,        1'b1, 2'd3, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 2'd1, 1'b0, 32'h321, 32'h0,        32'h0,        1'b1, 2'd1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h31C, 32'h0,        32'h0,        1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b0, 1'b1, 2'd2, 1'b0, 32'h28,  32'h77,       32'h0,        1'b0, 2'd0, 2, 0, 1, 32'h77);
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h28,  32'h0,        32'h77,       1'b0, 2'd0, FWD ? 1 : 2, FWD ? 0 : 1, 0, 32'h0);
    add(1'b1, 1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        32'hFFFFABF0, 1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 2'd0, 1'b0, 32'h23,  32'h0,        32'h000000AB, 1'b0, 2'd0, 2, 1, 0, 32'h0);
    add(1'b0, 1'b1, 2'd1, 1'b0, 32'h22,  32'hDEAD1234, 32'h0,        1'b0, 2'd0, 3, 1, 2, 32'h1234F0F0);
    add(1'b1, 1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h1234F0F0, 1'b0, 2'd0, FWD ? 1 : 2, FWD ? 0 : 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    check("rst_done", 32'(ls_done), 32'd0);
    check("rst_fault", 32'(ls_fault), 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_cause", 32'(ls_cause), 32'd0);
    check("rst_rdata", ls_rdata, 32'h0);
    check("rst_aluout", ALUOut, 32'h0);
    check("rst_reg2data", reg2data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ls_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) begin
      model(vq[i].ld, vq[i].st, vq[i].sz, vq[i].sg, vq[i].addr, vq[i].wd, m);
      apply(vq[i], $sformatf("vec%0d", i));
    end

    // reset in the WR cycle of a byte store must not let the write land
    for (int i = 0; i < 10 && !ls_ready; i++) @(negedge clk);
    ls_valid = 1'b1; ls_store = 1'b1; ls_load = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
    ls_addr = 32'h28; ls_wdata = 32'h11;
    @(posedge clk);
    #1;
    ls_valid = 1'b0; ls_store = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (MemWrite) seen = 1'b1;
    end
    check("abort_write_reached", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_memread", 32'(MemRead), 32'd0);
    check("abort_done", 32'(ls_done), 32'd0);
    check("abort_fault", 32'(ls_fault), 32'd0);
    check("abort_cause", 32'(ls_cause), 32'd0);
    check("abort_rdata", ls_rdata, 32'h0);
    check("abort_aluout", ALUOut, 32'h0);
    check("abort_reg2data", reg2data, 32'h0);
    @(posedge clk);
    #1;
    check("abort_mem_kept", mem[10], 32'h77);
    @(negedge clk);
    rst_n = 1'b1;
    lw_vld = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ls_ready), 32'd1);
    model(1'b1, 1'b0, 2'd2, 1'b0, 32'h28, 32'h0, m);
    apply(m, "abort_reload");

    // randomized requests against the reference model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      begin ld = 1'b1; st = 1'b1; end
      else if (r == 1) begin ld = 1'b0; st = 1'b0; end
      else             begin ld = (r < 10); st = !(r < 10); end
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(196, 209)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lo = 2'($urandom_range(0, 3));
      else if (sz == 2'd0)           lo = 2'($urandom_range(0, 3));
      else if (sz == 2'd1)           lo = {1'($urandom_range(0, 1)), 1'b0};
      else                           lo = 2'd0;
      model(ld, st, sz, 1'($urandom_range(0, 1)), 32'(idx * 4) | 32'(lo), $urandom(), m);
      apply(m, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
